usb_rx_bit_timer: RTL

Bit-timing controller for the USB receive path. It sits downstream of `edge_detect` and consumes its `d_edge` pulse to resynchronise a per-bit phase counter. It issues one `shift_enable` pulse per bit at a fixed sample point, which drives the RX shift register. It counts bits and flags each completed byte to the receiver control unit (RCU), which gates it through `rcving`.

---
 rtl/usb_rx_bit_timer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/usb_rx_bit_timer.sv
// USB RX bit timer: edge-resynchronised phase counter, sample strobe, bit/byte count.
// Optional bit-stuff removal under `RX_STUFF_SKIP_EN.
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       rcving,
  input  logic       d_orig,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [2:0] bit_count,
  output logic       stuff_skip
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [2:0]      bit_count_q, bit_count_d;
  logic            byte_rx_q, byte_rx_d;
  logic            sample;
  logic            stuff;

  assign sample = (state_q == RUN) &&
                  (phase_q == PW'(SAMPLE_POINT));

`ifdef RX_STUFF_SKIP_EN
  logic [2:0] ones_q, ones_d;

  // Six ones already seen: this sample is the stuffed zero.
  assign stuff = sample && (ones_q == 3'd6);

  always_comb begin
    ones_d = ones_q;
    if (state_q == IDLE || !rcving) begin
      ones_d = 3'd0;
    end else if (sample) begin
      if (stuff || !d_orig) begin
        ones_d = 3'd0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_q <= 3'd0;
    end else begin
      ones_q <= ones_d;
    end
  end
`else
  logic unused_d_orig;
  assign unused_d_orig = d_orig;
  assign stuff = 1'b0;
`endif

  assign shift_enable  = sample && !stuff;
  assign stuff_skip    = stuff;
  assign byte_received = byte_rx_q;
  assign bit_count     = bit_count_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_count_d = bit_count_q;
    byte_rx_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rcving) begin
          state_d = RUN;
          phase_d = PW'(1);
        end
      end
      RUN: begin
        if (!rcving) begin
          state_d     = IDLE;
          phase_d     = '0;
          bit_count_d = 3'd0;
        end else begin
          if (d_edge) begin
            phase_d = PW'(1);
          end else if (phase_q == PW'(CLKS_PER_BIT - 1)) begin
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
          if (shift_enable) begin
            if (bit_count_q == 3'd7) begin
              bit_count_d = 3'd0;
              byte_rx_d   = 1'b1;
            end else begin
              bit_count_d = bit_count_q + 3'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_count_q <= 3'd0;
      byte_rx_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_count_q <= bit_count_d;
      byte_rx_q   <= byte_rx_d;
    end
  end

endmodule
